// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the pipelined AND/XOR logic unit.
// Mode encodings for the E result and the per-bit E evaluator.
// Used by the stage-2 evaluator; no state lives here.
package logic_pipe_pkg;

  localparam logic [1:0] MODE_XOR  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_XNOR = 2'd2;
  localparam logic [1:0] MODE_ANDN = 2'd3;

  // One bit of E from operand a and the pre-combined b&c term.
  function automatic logic e_sel(input logic [1:0] m, input logic a, input logic bc);
    logic r;
    r = 1'b0;
    case (m)
      MODE_XOR:  r = a ^ bc;
      MODE_OR:   r = a | bc;
      MODE_XNOR: r = ~(a ^ bc);
      MODE_ANDN: r = a & ~bc;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_fn.sv
// Combinational evaluator of D = a & bc and E = f(mode, a, bc).
// Latency: zero (pure combinational), sits in front of the stage-2 registers.
// Backpressure: none; the caller decides when the results are captured.
module logic_pipe_fn
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] bc_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] d_o,
  output logic [WIDTH-1:0] e_o
);

  // Bitwise evaluation; the mode applies uniformly across all bits.
  always_comb begin
    d_o = a_i & bc_i;
    e_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      e_o[i] = e_sel(mode_i, a_i[i], bc_i[i]);
    end
  end

endmodule

// File: rtl/logic_pipe_unit.sv
// Two-stage pipelined D = A&B&C / mode-selected E unit with nonzero-D event counter.
// Latency: operands accepted at edge N appear on D/E with out_valid after edge N+1.
// Backpressure: full valid/ready; in_ready falls combinationally when both stages are held.
module logic_pipe_unit
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] nz_cnt
);

  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] bc1_q;
  logic [1:0]       mode1_q;

  logic             v2_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] e_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             adv1;
  logic             adv2;
  logic             out_fire;
  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] e_nxt;

  // A stage may advance when it is empty or the stage after it is moving.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign out_fire = v2_q && out_ready;

  // Stage 1: capture A, the pre-reduced B&C and the mode of this transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      bc1_q   <= '0;
      mode1_q <= MODE_XOR;
    end else if (adv1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q    <= A;
        bc1_q   <= B & C;
        mode1_q <= mode;
      end
    end
  end

  logic_pipe_fn #(
    .WIDTH(WIDTH)
  ) u_fn (
    .a_i   (a1_q),
    .bc_i  (bc1_q),
    .mode_i(mode1_q),
    .d_o   (d_nxt),
    .e_o   (e_nxt)
  );

  // Stage 2: register results; bubbles move v2 but leave D/E untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      d_q  <= '0;
      e_q  <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        d_q <= d_nxt;
        e_q <= e_nxt;
      end
    end
  end

  // Counter next state: clear wins, otherwise saturating increment on a nonzero-D delivery.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire && (d_q != '0) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = v2_q;
  assign D         = d_q;
  assign E         = e_q;
  assign nz_cnt    = cnt_q;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Scoreboard bench for logic_pipe_unit: a default-width instance plus a CNT_W=2 instance
// sharing all inputs, so counter saturation is visible in a few transfers.
// Expected D/E come from hand-computed vectors pushed at acceptance, popped at delivery.
module tb_logic_pipe_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         cnt_clr;
  logic [W-1:0] A, B, C;
  logic [1:0]   mode;

  logic         in_ready, out_valid;
  logic [W-1:0] D, E;
  logic [15:0]  nz_cnt;

  logic         in_ready_s, out_valid_s;
  logic [W-1:0] D_s, E_s;
  logic [1:0]   nz_cnt_s;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0]   exp_d, exp_e;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] sb_item;
  logic           held = 1'b0;
  logic [W-1:0]   held_d, held_e;

  always #5 clk = ~clk;

  logic_pipe_unit #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .E(E), .cnt_clr(cnt_clr), .nz_cnt(nz_cnt)
  );

  logic_pipe_unit #(.WIDTH(W), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .C(C), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready),
    .D(D_s), .E(E_s), .cnt_clr(cnt_clr), .nz_cnt(nz_cnt_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: deliveries pop and compare, stalls are checked for stability, acceptances push.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_vld", {31'd0, out_valid}, 32'd1);
        chk("hold_d", {24'd0, D}, {24'd0, held_d});
        chk("hold_e", {24'd0, E}, {24'd0, held_e});
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_out: D=%0h E=%0h with nothing expected at %0t", D, E, $time);
          end else begin
            sb_item = sb_q.pop_front();
            chk("out_d", {24'd0, D}, {24'd0, sb_item[2*W-1:W]});
            chk("out_e", {24'd0, E}, {24'd0, sb_item[W-1:0]});
            chk("s_vld", {31'd0, out_valid_s}, 32'd1);
            chk("s_d", {24'd0, D_s}, {24'd0, sb_item[2*W-1:W]});
            chk("s_e", {24'd0, E_s}, {24'd0, sb_item[W-1:0]});
          end
        end else begin
          held   = 1'b1;
          held_d = D;
          held_e = E;
        end
      end
      if (in_valid && in_ready) sb_q.push_back({exp_d, exp_e});
    end
  end

  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [1:0] m, input logic [W-1:0] ed, input logic [W-1:0] ee);
    in_valid = 1'b1;
    A = a; B = b; C = c; mode = m;
    exp_d = ed; exp_e = ee;
  endtask

  // Returns one step after the accepting edge, in_valid still asserted.
  task automatic wait_accept();
    int bud = 0;
    @(negedge clk);
    while (!in_ready && bud < 50) begin
      @(negedge clk);
      bud++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [1:0] m, input logic [W-1:0] ed, input logic [W-1:0] ee);
    set_in(a, b, c, m, ed, ee);
    wait_accept();
  endtask

  task automatic wait_empty();
    int bud = 0;
    while (sb_q.size() != 0 && bud < 100) begin
      @(posedge clk);
      bud++;
    end
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
    end
  endtask

  task automatic xfer(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [1:0] m, input logic [W-1:0] ed, input logic [W-1:0] ee);
    drive(a, b, c, m, ed, ee);
    in_valid = 1'b0;
    wait_empty();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    #2 rst_n = 1'b0;
    held = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    A = '0; B = '0; C = '0; mode = 2'd0; exp_d = '0; exp_e = '0;
    rst_n = 1'b0;

    // Reset state
    #3;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {24'd0, D}, 32'd0);
    chk("rst_e", {24'd0, E}, 32'd0);
    chk("rst_cnt", {16'd0, nz_cnt}, 32'd0);
    chk("rst_cnt_s", {30'd0, nz_cnt_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Single transfer with latency check: bc=88, D=80, E=F0^88=78
    drive(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    in_valid = 1'b0;
    chk("lat_n", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_n1", {31'd0, out_valid}, 32'd1);
    wait_empty();
    chk("cnt_single", {16'd0, nz_cnt}, 32'd1);

    // Mode stream, back-to-back: OR=F8, XNOR=87, ANDN=F0&77=70
    drive(8'hF0, 8'hCC, 8'hAA, 2'd1, 8'h80, 8'hF8);
    drive(8'hF0, 8'hCC, 8'hAA, 2'd2, 8'h80, 8'h87);
    drive(8'hF0, 8'hCC, 8'hAA, 2'd3, 8'h80, 8'h70);
    in_valid = 1'b0;
    wait_empty();
    chk("cnt_stream", {16'd0, nz_cnt}, 32'd4);
    chk("cnt_stream_sat", {30'd0, nz_cnt_s}, 32'd3);

    // Backpressure: two accepts fill the pipe, third waits
    out_ready = 1'b0;
    drive(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    drive(8'hFF, 8'hFF, 8'hFF, 2'd1, 8'hFF, 8'hFF);
    set_in(8'h3C, 8'h5A, 8'hFF, 2'd3, 8'h18, 8'h24);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_in_ready_s", {31'd0, in_ready_s}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_nogap1", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("bp_nogap2", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_empty();
    chk("cnt_bp", {16'd0, nz_cnt}, 32'd7);

    // Saturation on the 2-bit counter: 1,2,3,3,3
    do_reset();
    chk("sat_rst", {30'd0, nz_cnt_s}, 32'd0);
    xfer(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    chk("sat_1", {30'd0, nz_cnt_s}, 32'd1);
    xfer(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    chk("sat_2", {30'd0, nz_cnt_s}, 32'd2);
    xfer(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    chk("sat_3", {30'd0, nz_cnt_s}, 32'd3);
    xfer(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    chk("sat_4", {30'd0, nz_cnt_s}, 32'd3);
    xfer(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    chk("sat_5", {30'd0, nz_cnt_s}, 32'd3);
    chk("wide_5", {16'd0, nz_cnt}, 32'd5);

    // Clear coincident with a qualifying handshake
    drive(8'hF0, 8'hCC, 8'hAA, 2'd0, 8'h80, 8'h78);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_vld", {31'd0, out_valid}, 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_cnt", {16'd0, nz_cnt}, 32'd0);
    chk("clr_cnt_s", {30'd0, nz_cnt_s}, 32'd0);

    // Nonzero then zero-D deliveries: 3C&5A=18 (ANDN 24), then D=0 leaves the count alone
    xfer(8'h3C, 8'h5A, 8'hFF, 2'd3, 8'h18, 8'h24);
    chk("nz_after", {16'd0, nz_cnt}, 32'd1);
    xfer(8'h0F, 8'hF0, 8'hFF, 2'd0, 8'h00, 8'hFF);
    chk("zero_d_cnt", {16'd0, nz_cnt}, 32'd1);
    xfer(8'h00, 8'h00, 8'h00, 2'd2, 8'h00, 8'hFF);
    chk("zero_d_cnt2", {30'd0, nz_cnt_s}, 32'd1);

    // Reset with both stages occupied
    out_ready = 1'b0;
    drive(8'hF0, 8'hCC, 8'hAA, 2'd1, 8'h80, 8'hF8);
    drive(8'hFF, 8'hFF, 8'hFF, 2'd0, 8'hFF, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    held = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_vld_s", {31'd0, out_valid_s}, 32'd0);
    chk("mid_d", {24'd0, D}, 32'd0);
    chk("mid_cnt", {16'd0, nz_cnt}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
